voice_dispatcher: RTL and testbench
===================================

// Module: voice_dispatcher
// PURPOSE
//  Sequences polyphonic playback. Accepts note requests (note, duration) from the song reader over a valid/ready handshake.
//  Assigns each request to the lowest-index idle note player voice, issuing that voice's one-cycle load strobe.
//  Tracks per-voice busy state from the voices' done_with_note pulses.
//  Executes rests (note 0) internally by counting beats, without occupying a voice.
//  Sits between the song reader and an array of NUM_VOICES note players feeding the sample mixer.
// PARAMETERS
//  NUM_VOICES  3  number of note players under control (1..8)
//  NOTE_W      6  width of note code; code 0 = rest
//  DUR_W       6  width of duration field (in 1/48 s beats)
// PORTS
//  clk           in   1           system clock; single clock domain
//  reset         in   1           synchronous, active-high reset
//  play_enable   in   1           global run/pause
//  beat          in   1           1/48 s beat strobe, one cycle wide
//  req_valid     in   1           song reader has a request
//  req_note      in   NOTE_W      requested note (0 = rest)
//  req_duration  in   DUR_W       requested duration
//  req_ready     out  1           request accepted this cycle when req_valid && req_ready
//  voice_done    in   NUM_VOICES  done_with_note from each voice
//  voice_load    out  NUM_VOICES  one-hot load_new_note strobe to voices
//  voice_note    out  NOTE_W      shared note_to_load bus
//  voice_dur     out  DUR_W       shared duration_to_load bus
//  voice_busy    out  NUM_VOICES  voice i currently holds a note
//  all_idle      out  1           no voice busy, FSM in IDLE
// BEHAVIOUR
//  Reset (sync): state=IDLE; voice_busy, voice_load, voice_note, voice_dur, rest counter all 0.
//   req_ready=0 during reset cycle; all_idle=1 after.
//  FSM states:
//   IDLE: req_ready = play_enable && (rest request || any voice free).
//    On accept with note!=0: latch note/dur onto voice_note/voice_dur; latch target voice = lowest-index free voice; go to LOAD.
//    On accept with note==0: rest_cnt<=req_duration; go to REST.
//   LOAD: voice_load[target]=1 for exactly this one cycle; voice_busy[target]<=1; next IDLE; req_ready=0.
//    Latency: accept at cycle N -> voice_load at N+1; voice_note/voice_dur stable from N+1 until next accept.
//   REST: req_ready=0. On beat && play_enable: if rest_cnt==0 go to IDLE, else rest_cnt-1.
//    A rest of duration d lasts d+1 beats, matching note player semantics.
//  Backpressure: all voices busy and note!=0 -> req_ready=0, request held by source; no voice stealing.
//  Busy clear: voice_done[i] && voice_busy[i] -> voice_busy[i]<=0 next cycle. voice_done on an idle voice is ignored.
//  Simultaneous voice_done[i] and voice_load[i]: load wins, voice_busy[i] stays 1.
//  Freed-voice reuse: a voice freed at cycle N is selectable by a request accepted at N+1 (busy is a register).
//  play_enable=0: req_ready=0; rest_cnt frozen; LOAD still completes its single strobe; voice_busy unchanged.
//  Reset mid-LOAD or mid-REST: strobe suppressed, state IDLE, all busy cleared.
//  all_idle = (state==IDLE) && ~|voice_busy.
// STRUCTURE
//  Shared include voice_defs.vh:
//   NOTE_REST=0; state encodings ST_IDLE=2'd0, ST_LOAD=2'd1, ST_REST=2'd2.
//  Sub-module lowest_free_select:
//   combinational priority encoder over ~voice_busy.
//   Outputs: one-hot grant, any_free.
//  All state held in dffr/dffre flops. Rest counter is DUR_W bits.
// TESTING
//  1 Reset, then req(note=5,dur=3) -> req_ready=1; voice_load=3'b001 one cycle later; voice_note=5, voice_dur=3; voice_busy=3'b001.
//  2 Three back-to-back reqs (notes 5,9,12) -> loads 001,010,100 on alternating cycles.
//     4th req held (req_ready=0) until voice_done[1] pulses; then 4th goes to voice 1 (load=010).
//  3 req(note=0,dur=2) -> no voice_load; req_ready=0 for exactly 3 beats.
//     Next req accepted the cycle after the 3rd beat.
//  4 voice_done[0] asserted while voice_busy[0]=0 -> no change.
//     voice_done[2] in same cycle as voice_load[2] -> voice_busy[2] remains 1.
//  5 play_enable=0 during REST with rest_cnt=1, 4 beats -> counter unchanged, req_ready=0.
//     Re-enable -> REST ends after 2 more beats.
//  6 reset asserted in LOAD cycle -> voice_load=0 that cycle; voice_busy=0; all_idle=1 next cycle.

Source files
------------

// File: rtl/voice_dispatcher_pkg.sv
// voice_dispatcher_pkg: shared FSM encoding and rest code for the voice dispatcher
package voice_dispatcher_pkg;
  localparam int NOTE_REST = 0;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_REST = 2'd2} state_t;
endpackage

// File: rtl/voice_dispatcher_lowest_free_select.sv
// lowest_free_select: one-hot grant of the lowest-index idle voice
module lowest_free_select #(
  parameter int N = 3
) (
  input  logic [N-1:0] busy,
  output logic [N-1:0] grant,
  output logic         any_free
);
  // adding one ripples through the low busy run, leaving the first clear bit set
  assign grant = ~busy & (busy + N'(1));
  assign any_free = ~&busy;
endmodule

// File: rtl/voice_dispatcher.sv
// voice_dispatcher: assigns note requests to the lowest idle voice and times rests on beats
module voice_dispatcher
  import voice_dispatcher_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W = 6,
  parameter int DUR_W = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  beat,
  input  logic                  req_valid,
  input  logic [NOTE_W-1:0]     req_note,
  input  logic [DUR_W-1:0]      req_duration,
  output logic                  req_ready,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_dur,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic                  all_idle
);
  state_t state;
  logic [NUM_VOICES-1:0] grant, target;
  logic [DUR_W-1:0] rest_cnt;
  logic any_free, rest_req, accept;
  lowest_free_select #(.N(NUM_VOICES)) u_select (
    .busy(voice_busy),
    .grant(grant),
    .any_free(any_free)
  );
  assign rest_req = req_note == NOTE_W'(NOTE_REST);
  assign req_ready = ~reset && play_enable && state == ST_IDLE && (rest_req || any_free);
  assign accept = req_valid && req_ready;
  // gated by reset so a reset landing on the load cycle drops the strobe
  assign voice_load = (state == ST_LOAD && ~reset) ? target : '0;
  assign all_idle = state == ST_IDLE && ~|voice_busy;
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_IDLE;
      voice_busy <= '0;
      voice_note <= '0;
      voice_dur <= '0;
      rest_cnt <= '0;
      target <= '0;
    end else begin
      voice_busy <= (voice_busy & ~voice_done) | voice_load;
      case (state)
        ST_IDLE:
          if (accept) begin
            state <= rest_req ? ST_REST : ST_LOAD;
            if (rest_req) rest_cnt <= req_duration;
            else begin
              voice_note <= req_note;
              voice_dur <= req_duration;
              target <= grant;
            end
          end
        ST_LOAD: state <= ST_IDLE;
        ST_REST:
          if (beat && play_enable) begin
            if (rest_cnt == '0) state <= ST_IDLE;
            else rest_cnt <= rest_cnt - DUR_W'(1);
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_voice_dispatcher.sv
// tb_voice_dispatcher: table vectors, hand sequences and a load scoreboard for voice_dispatcher
module tb_voice_dispatcher;
  logic clk = 0, reset = 1, play_enable = 1, beat = 0, req_valid = 0;
  logic [5:0] req_note = 0, req_duration = 0, voice_note, voice_dur;
  logic [2:0] voice_done = 0, voice_load, voice_busy;
  logic req_ready, all_idle;
  int checks = 0, errors = 0;

  typedef struct packed {logic [2:0] load; logic [5:0] note; logic [5:0] dur;} exp_t;
  exp_t sb[$];
  logic [2:0] mbusy = 0, pend = 0;

  typedef struct {logic [5:0] note; logic [5:0] dur; int wait_cyc; logic [2:0] load;} vec_t;
  vec_t vecs[3];

  voice_dispatcher dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .req_valid(req_valid), .req_note(req_note), .req_duration(req_duration),
    .req_ready(req_ready), .voice_done(voice_done), .voice_load(voice_load),
    .voice_note(voice_note), .voice_dur(voice_dur), .voice_busy(voice_busy),
    .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [2:0] b);
    for (int i = 0; i < 3; i++) if (!b[i]) return 3'b001 << i;
    return 3'b000;
  endfunction

  // scoreboard: expected loads are queued at handshake time and matched to strobes
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t e;
    if (reset) begin
      sb.delete();
      mbusy = 0;
      pend = 0;
    end else begin
      cur = mbusy;
      check("busy model", voice_busy, cur);
      if (voice_load != 0) begin
        if (sb.size() == 0) check("unexpected load", voice_load, 0);
        else begin
          e = sb.pop_front();
          check("sb load", voice_load, e.load);
          check("sb note", voice_note, e.note);
          check("sb dur", voice_dur, e.dur);
        end
      end
      mbusy = (cur & ~voice_done) | pend;
      pend = 0;
      if (req_valid && req_ready && req_note != 0) begin
        e = '{load: lowest(cur), note: req_note, dur: req_duration};
        sb.push_back(e);
        pend = e.load;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] n, input logic [5:0] d, input int exp_wait, input string tag);
    int w = 0;
    req_valid = 1;
    req_note = n;
    req_duration = d;
    #1;
    while (!req_ready && w < 40) begin
      step();
      #1;
      w++;
    end
    check({tag, " wait"}, w, exp_wait);
    if (req_ready) step();
    req_valid = 0;
  endtask

  task automatic release_all;
    voice_done = 3'b111;
    step();
    voice_done = 0;
  endtask

  initial begin
    vecs[0] = '{note: 6'd5, dur: 6'd3, wait_cyc: 0, load: 3'b001};
    vecs[1] = '{note: 6'd9, dur: 6'd4, wait_cyc: 1, load: 3'b010};
    vecs[2] = '{note: 6'd12, dur: 6'd5, wait_cyc: 1, load: 3'b100};
    req_valid = 1;
    req_note = 5;
    step();
    check("ready in reset", req_ready, 0);
    reset = 0;
    req_valid = 0;
    #1;
    check("reset all_idle", all_idle, 1);
    check("reset busy", voice_busy, 0);
    check("reset load", voice_load, 0);
    check("reset note", voice_note, 0);
    check("reset dur", voice_dur, 0);
    step();
    send(5, 3, 0, "t1");
    #1;
    check("t1 load", voice_load, 3'b001);
    check("t1 note", voice_note, 5);
    check("t1 dur", voice_dur, 3);
    step();
    check("t1 busy", voice_busy, 3'b001);
    check("t1 strobe ends", voice_load, 0);
    release_all();
    check("t1 cleared", voice_busy, 0);
    for (int i = 0; i < 3; i++) begin
      send(vecs[i].note, vecs[i].dur, vecs[i].wait_cyc, "t2 vec");
      #1;
      check("t2 load", voice_load, vecs[i].load);
      check("t2 note", voice_note, vecs[i].note);
      check("t2 dur", voice_dur, vecs[i].dur);
    end
    req_valid = 1;
    req_note = 7;
    req_duration = 2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2 held", req_ready, 0);
      step();
    end
    voice_done = 3'b010;
    #1;
    check("t2 held at done", req_ready, 0);
    step();
    voice_done = 0;
    send(7, 2, 0, "t2 fourth");
    #1;
    check("t2 fourth load", voice_load, 3'b010);
    step();
    release_all();
    check("t2 idle", all_idle, 1);
    send(0, 2, 0, "t3 rest");
    #1;
    check("t3 no load", voice_load, 0);
    req_valid = 1;
    req_note = 3;
    req_duration = 1;
    for (int b = 0; b < 3; b++) begin
      repeat (2) begin
        #1;
        check("t3 ready low", req_ready, 0);
        step();
      end
      beat = 1;
      #1;
      check("t3 ready at beat", req_ready, 0);
      step();
      beat = 0;
    end
    #1;
    check("t3 ready after rest", req_ready, 1);
    send(3, 1, 0, "t3 next");
    #1;
    check("t3 next load", voice_load, 3'b001);
    step();
    release_all();
    voice_done = 3'b001;
    step();
    voice_done = 0;
    check("t4 idle done busy", voice_busy, 0);
    check("t4 idle done all_idle", all_idle, 1);
    send(1, 1, 0, "t4 a");
    send(2, 1, 1, "t4 b");
    send(4, 1, 1, "t4 c");
    #1;
    check("t4 c load", voice_load, 3'b100);
    voice_done = 3'b100;
    step();
    voice_done = 0;
    check("t4 load wins", voice_busy, 3'b111);
    release_all();
    send(0, 2, 0, "t5 rest");
    beat = 1;
    step();
    beat = 0;
    play_enable = 0;
    req_valid = 1;
    req_note = 6;
    req_duration = 1;
    repeat (4) begin
      step();
      beat = 1;
      #1;
      check("t5 paused ready", req_ready, 0);
      step();
      beat = 0;
    end
    play_enable = 1;
    step();
    beat = 1;
    #1;
    check("t5 reenable beat1", req_ready, 0);
    step();
    beat = 0;
    #1;
    check("t5 after beat1", req_ready, 0);
    step();
    beat = 1;
    step();
    beat = 0;
    #1;
    check("t5 after beat2", req_ready, 1);
    send(6, 1, 0, "t5 next");
    #1;
    check("t5 next load", voice_load, 3'b001);
    step();
    send(8, 1, 0, "t6");
    reset = 1;
    #1;
    check("t6 load in reset", voice_load, 0);
    step();
    reset = 0;
    check("t6 busy", voice_busy, 0);
    check("t6 all_idle", all_idle, 1);
    step();
    check("t6 busy later", voice_busy, 0);
    check("sb drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
